// File: rtl/rx_bit_sampler.sv
// rtl/rx_bit_sampler.sv - UART RX oversampling front end: line synchronizer, edge/bit counters,
// three-sample majority vote around the bit centre.
module rx_bit_sampler #(
   parameter int PRESCALE_WIDTH = 6,
   parameter int FRAME_BITS     = 11
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   input  logic                      edge_cnt_en,
   input  logic                      dat_samp_en,
   output logic                      rx_sync,
   output logic [PRESCALE_WIDTH-1:0] edge_cnt,
   output logic [3:0]                bit_cnt,
   output logic                      sampled_bit,
   output logic                      sample_valid
);
   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   logic                      sync_meta;
   logic                      en_q;
   logic                      en_rise;
   logic [PRESCALE_WIDTH-1:0] p_reg;
   logic [PRESCALE_WIDTH-1:0] p_eff;
   logic [PRESCALE_WIDTH-1:0] p_last;
   logic [PRESCALE_WIDTH-1:0] half;
   logic [PRESCALE_WIDTH-1:0] pos_a;
   logic [PRESCALE_WIDTH-1:0] pos_b;
   logic [PRESCALE_WIDTH-1:0] pos_c;
   logic                      s0;
   logic                      s1;
   logic                      s2;
   logic                      have_a;
   logic                      have_b;

   assign en_rise = edge_cnt_en & ~en_q;
   // The first enabled cycle already counts against the ratio being latched.
   assign p_eff  = en_rise ? Prescale : p_reg;
   assign p_last = p_eff - PRESCALE_WIDTH'(1);
   assign half   = p_eff >> 1;
   assign pos_a  = half - PRESCALE_WIDTH'(1);
   assign pos_b  = half;
   assign pos_c  = half + PRESCALE_WIDTH'(1);

   always_ff @(posedge CLK) begin
      if (RST) begin
         sync_meta <= 1'b1;
         rx_sync   <= 1'b1;
      end else begin
         sync_meta <= RX_IN;
         rx_sync   <= sync_meta;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         en_q  <= 1'b0;
         p_reg <= PRESCALE_WIDTH'(8);
      end else begin
         en_q <= edge_cnt_en;
         if (en_rise) begin
            p_reg <= Prescale;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST || !edge_cnt_en) begin
         edge_cnt <= '0;
         bit_cnt  <= '0;
      end else if (edge_cnt == p_last) begin
         edge_cnt <= '0;
         bit_cnt  <= (bit_cnt == LAST_BIT) ? 4'd0 : bit_cnt + 4'd1;
      end else begin
         edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
      end
   end

   // have_a/have_b track an unbroken capture window so a partial window never votes.
   always_ff @(posedge CLK) begin
      if (RST) begin
         s0           <= 1'b1;
         s1           <= 1'b1;
         s2           <= 1'b1;
         have_a       <= 1'b0;
         have_b       <= 1'b0;
         sampled_bit  <= 1'b1;
         sample_valid <= 1'b0;
      end else begin
         sample_valid <= 1'b0;
         if (!dat_samp_en) begin
            have_a <= 1'b0;
            have_b <= 1'b0;
         end else if (edge_cnt == pos_a) begin
            s0     <= rx_sync;
            have_a <= 1'b1;
         end else if (edge_cnt == pos_b) begin
            s1     <= rx_sync;
            have_b <= have_a;
         end else if (edge_cnt == pos_c) begin
            s2     <= rx_sync;
            have_a <= 1'b0;
            have_b <= 1'b0;
            if (have_b) begin
               sampled_bit  <= (s0 & s1) | (s0 & rx_sync) | (s1 & rx_sync);
               sample_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/rx_bit_sampler.md
# rx_bit_sampler

Oversampling front end of the UART receiver. It synchronizes the raw serial line and counts oversampling edges and bit periods. It takes three samples around the centre of each bit and majority-votes them into `sampled_bit`, with a one-cycle valid strobe. Its outputs feed the deserializer, the parity and stop checkers and the RX control FSM, which uses `edge_cnt`/`bit_cnt` to sequence the frame and raise `par_chk_en`.

## Interface
- `PRESCALE_WIDTH`, default 6: width of the `Prescale` input; it covers oversampling ratios 8, 16 and 32.
- `FRAME_BITS`, default 11: bit periods per frame (start + 8 data + parity + stop); `bit_cnt` wraps after `FRAME_BITS-1`.
- `CLK`, input, 1: oversampling clock; all logic is on the rising edge.
- `RST`, input, 1: synchronous, active-high reset.
- `RX_IN`, input, 1: raw serial line, asynchronous to `CLK`; idle level is 1.
- `Prescale`, input, `PRESCALE_WIDTH`: oversampling ratio; legal values are even and ≥ 8.
- `edge_cnt_en`, input, 1: enables the edge and bit counters; low clears them.
- `dat_samp_en`, input, 1: enables the sample capture and the vote.
- `rx_sync`, output, 1: synchronized `RX_IN`, used by the FSM for start-bit detection.
- `edge_cnt`, output, `PRESCALE_WIDTH`: edge position within the current bit, 0..P-1.
- `bit_cnt`, output, 4: bit index within the frame, 0..`FRAME_BITS-1`.
- `sampled_bit`, output, 1: majority-voted value of the current bit; holds until the next vote.
- `sample_valid`, output, 1: one-cycle strobe, high in the cycle `sampled_bit` updates.

## Operation
- **Synchronizer:** a 2-flop synchronizer drives `rx_sync`, giving 2 cycles from `RX_IN` to `rx_sync`. Both flops reset to 1. Every sample below is taken from `rx_sync`.
- **Prescale latch:**
  - The internal ratio P is latched from `Prescale` on the cycle `edge_cnt_en` goes 0→1.
  - Changes to `Prescale` while `edge_cnt_en`=1 are ignored until the next rising edge of `edge_cnt_en`.
  - P resets to 8.
- **Edge counter:**
  - While `edge_cnt_en`=1, `edge_cnt` increments each cycle.
  - When `edge_cnt`=P-1, it wraps to 0 on the next cycle and `bit_cnt` increments.
  - When `bit_cnt`=`FRAME_BITS-1` and `edge_cnt`=P-1, both wrap to 0.
- **Counter clear:** `edge_cnt_en`=0 forces `edge_cnt`=0 and `bit_cnt`=0 on the next edge, regardless of their current values.
- **Sampling:**
  - Let H = P>>1.
  - With `dat_samp_en`=1, `rx_sync` is captured into s0, s1 and s2 at `edge_cnt` = H-1, H and H+1.
  - At `edge_cnt`=H+2, `sampled_bit` is updated to the majority (s0&s1 | s0&s2 | s1&s2) and `sample_valid` is 1 for that cycle only.
- **`dat_samp_en` low:**
  - No captures occur and `sample_valid` stays 0. `sampled_bit` holds.
  - If it goes low partway through a capture window, the partial samples are discarded. No strobe is produced for that bit.
- **Illegal `Prescale`** (odd or < 8): the counters still wrap at P-1, but sample positions are not guaranteed. There is no error output.

## Timing
- **Reset values:** `rx_sync`=1, `edge_cnt`=0, `bit_cnt`=0, `sampled_bit`=1, `sample_valid`=0, s0..s2=1, P=8.
- **Reset mid-frame:** all state, including P and the synchronizer, returns to reset values on the next edge. There is no residual strobe.
- **Strobe latency:** `sample_valid` goes high H+2 cycles after `edge_cnt`=0 of the same bit. That is 3 cycles after the first capture and 1 cycle after the last capture.
- **`bit_cnt` alignment:** `bit_cnt` changes in the same cycle `edge_cnt` returns to 0. During `sample_valid`, `bit_cnt` still holds the index of the bit just voted.
- **Counter/sampling overlap:** `edge_cnt_en` clear and `dat_samp_en` are evaluated independently. If `edge_cnt_en`=0, `edge_cnt` stays 0, so only the capture at position 0 (H-1=0) is reachable. Because P≥8, this does not occur for legal P.
- **Single-bit FRAME_BITS:** if `FRAME_BITS`=1, `bit_cnt` stays 0.

## Test plan
- **Reset values:** assert `RST` for 2 cycles → every output equals its reset value. Drive `RX_IN`=0 → `rx_sync` falls exactly 2 cycles later.
- **Prescale 8, 11-bit frame:** `Prescale`=8, both enables=1, frame `RX_IN` = 0,10110011,1,1 → `sample_valid` pulses at `edge_cnt`=6 for each of 11 bits. `sampled_bit` sequence equals the frame. `bit_cnt` wraps 10→0.
- **Glitch rejection:** `Prescale`=16, bit=1 with `rx_sync`=0 only at `edge_cnt`=8 → `sampled_bit`=1. With `rx_sync`=0 at edges 7 and 9 → `sampled_bit`=0.
- **Prescale change mid-frame:** `Prescale`=32 latched, then changed to 8 at `bit_cnt`=3 → `edge_cnt` keeps wrapping at 31. After an `edge_cnt_en` 1→0→1 cycle, it wraps at 7.
- **Enable drop:** `edge_cnt_en`=0 at `edge_cnt`=5, `bit_cnt`=4 → both are 0 next cycle. Drop `dat_samp_en` at `edge_cnt`=H → no `sample_valid` for that bit and `sampled_bit` unchanged.
- **Reset mid-sample:** `RST` asserted at `edge_cnt`=H+1 with P=16 → no strobe at H+2. All outputs are at reset values on the next cycle.
